// File: rtl/ysyx_bpu_gshare_if.sv
// Fetch-side lookup and retire-side training bundle for the gshare next-PC predictor.
// The predictor connects to the slave modport, and the fetch/retire logic connects to the master modport.
interface ysyx_bpu_gshare_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] lk_pc;
    logic [31:0]     lk_inst;
    logic            lk_fire;
    logic [XLEN-1:0] out_pnpc;
    logic            out_ptaken;
    logic            upd_valid;
    logic            upd_is_br;
    logic            upd_is_jalr;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_npc;
    logic            flush;
    logic            fence_time;

    modport master (
        output lk_pc, lk_inst, lk_fire,
        output upd_valid, upd_is_br, upd_is_jalr, upd_pc, upd_npc,
        output flush, fence_time,
        input  out_pnpc, out_ptaken
    );

    modport slave (
        input  lk_pc, lk_inst, lk_fire,
        input  upd_valid, upd_is_br, upd_is_jalr, upd_pc, upd_npc,
        input  flush, fence_time,
        output out_pnpc, out_ptaken
    );
endinterface

// File: rtl/ysyx_bpu_gshare.sv
// Gshare next-PC predictor: a PHT indexed by the speculative history, a tagged BTB for JALR targets,
// and an optional return address stack that is built only when YSYX_BPU_RAS_EN is defined.
module ysyx_bpu_gshare #(
    parameter int XLEN      = 32,
    parameter int PHT_SIZE  = 64,
    parameter int CNT_W     = 2,
    parameter int GHR_W     = 6,
    parameter int BTB_SIZE  = 16,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input logic              clock,
    input logic              reset,
    ysyx_bpu_gshare_if.slave bus
);
    localparam int IW = $clog2(PHT_SIZE);
    localparam int BW = $clog2(BTB_SIZE);
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};

    logic [CNT_W-1:0] pht_q     [PHT_SIZE];
    logic [CNT_W-1:0] pht_d     [PHT_SIZE];
    logic [BTB_SIZE-1:0] btb_v_q, btb_v_d;
    logic [TAG_W-1:0] btb_tag_q [BTB_SIZE];
    logic [TAG_W-1:0] btb_tag_d [BTB_SIZE];
    logic [XLEN-1:0]  btb_tgt_q [BTB_SIZE];
    logic [XLEN-1:0]  btb_tgt_d [BTB_SIZE];
    logic [GHR_W-1:0] spec_ghr_q, spec_ghr_d;
    logic [GHR_W-1:0] ret_ghr_q, ret_ghr_d;

    logic [31:0]      inst;
    logic             is_br, is_jal, is_jalr;
    logic [XLEN-1:0]  imm_b, imm_j, pc4, pnpc;
    logic [IW-1:0]    pidx, uidx;
    logic [BW-1:0]    bidx, ubidx;
    logic [TAG_W-1:0] ltag, utag;
    logic             br_pred, btb_hit, jalr_hit;
    logic [XLEN-1:0]  jalr_tgt;
    logic             upd_br, upd_jalr, upd_taken;

    assign inst    = bus.lk_inst;
    assign is_br   = (inst[6:0] == 7'b1100011);
    assign is_jal  = (inst[6:0] == 7'b1101111);
    assign is_jalr = (inst[6:0] == 7'b1100111);
    assign imm_b   = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j   = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign pc4     = bus.lk_pc + XLEN'(4);

    assign pidx    = bus.lk_pc[IW+1:2] ^ IW'(spec_ghr_q);
    assign bidx    = bus.lk_pc[BW+1:2];
    assign ltag    = bus.lk_pc[BW+2+TAG_W-1:BW+2];
    assign br_pred = pht_q[pidx][CNT_W-1];
    assign btb_hit = btb_v_q[bidx] && (btb_tag_q[bidx] == ltag);

    assign upd_br    = bus.upd_valid && bus.upd_is_br;
    assign upd_jalr  = bus.upd_valid && bus.upd_is_jalr;
    assign upd_taken = (bus.upd_npc != bus.upd_pc + XLEN'(4));
    assign uidx      = bus.upd_pc[IW+1:2] ^ IW'(ret_ghr_q);
    assign ubidx     = bus.upd_pc[BW+1:2];
    assign utag      = bus.upd_pc[BW+2+TAG_W-1:BW+2];

`ifdef YSYX_BPU_RAS_EN
    localparam int RW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [RW-1:0]   ras_ptr_q, ras_ptr_d, ras_ptr_inc;
    logic [RW:0]     ras_cnt_q, ras_cnt_d;
    logic            rd_link, rs1_link, ras_push, ras_pop, ras_pred;

    assign rd_link     = (inst[11:7] == 5'd1) || (inst[11:7] == 5'd5);
    assign rs1_link    = (inst[19:15] == 5'd1) || (inst[19:15] == 5'd5);
    assign ras_push    = (is_jal || is_jalr) && rd_link;
    assign ras_pop     = is_jalr && rs1_link && (ras_cnt_q != '0);
    assign ras_pred    = ras_pop && !rd_link;
    assign ras_ptr_inc = ras_ptr_q + RW'(1);

    always_comb begin
        jalr_hit = btb_hit;
        jalr_tgt = btb_tgt_q[bidx];
        if (ras_pred) begin
            jalr_hit = 1'b1;
            jalr_tgt = ras_q[ras_ptr_q];
        end
    end

    // The pointer always addresses the top entry; a full push wraps onto the oldest slot.
    always_comb begin
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (bus.fence_time) begin
            ras_ptr_d = '0;
            ras_cnt_d = '0;
        end else if (bus.lk_fire && !bus.flush) begin
            if (ras_push && ras_pop) begin
                ras_d[ras_ptr_q] = pc4;
            end else if (ras_push) begin
                ras_ptr_d          = ras_ptr_inc;
                ras_d[ras_ptr_inc] = pc4;
                if (ras_cnt_q != (RW+1)'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + (RW+1)'(1);
            end else if (ras_pop) begin
                ras_ptr_d = ras_ptr_q - RW'(1);
                ras_cnt_d = ras_cnt_q - (RW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        ras_q <= ras_d;
    end
`else
    assign jalr_hit = btb_hit;
    assign jalr_tgt = btb_tgt_q[bidx];
`endif

    always_comb begin
        pnpc = pc4;
        if (is_br && br_pred)       pnpc = bus.lk_pc + imm_b;
        else if (is_jal)            pnpc = bus.lk_pc + imm_j;
        else if (is_jalr && jalr_hit) pnpc = jalr_tgt;
    end

    assign bus.out_pnpc   = pnpc;
    assign bus.out_ptaken = (pnpc != pc4);

    // Flush rebuilds the speculative history from the retired history, including this cycle's retire.
    always_comb begin
        pht_d      = pht_q;
        btb_v_d    = btb_v_q;
        btb_tag_d  = btb_tag_q;
        btb_tgt_d  = btb_tgt_q;
        spec_ghr_d = spec_ghr_q;
        ret_ghr_d  = ret_ghr_q;
        if (upd_br) begin
            if (upd_taken && (pht_q[uidx] != '1))
                pht_d[uidx] = pht_q[uidx] + CNT_W'(1);
            else if (!upd_taken && (pht_q[uidx] != '0))
                pht_d[uidx] = pht_q[uidx] - CNT_W'(1);
            ret_ghr_d = GHR_W'({ret_ghr_q, upd_taken});
        end
        if (upd_jalr) begin
            btb_v_d[ubidx]   = 1'b1;
            btb_tag_d[ubidx] = utag;
            btb_tgt_d[ubidx] = bus.upd_npc;
        end
        if (bus.flush)
            spec_ghr_d = ret_ghr_d;
        else if (bus.lk_fire && is_br)
            spec_ghr_d = GHR_W'({spec_ghr_q, br_pred});
        if (bus.fence_time) begin
            for (int i = 0; i < PHT_SIZE; i++) pht_d[i] = CNT_INIT;
            btb_v_d    = '0;
            spec_ghr_d = '0;
            ret_ghr_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PHT_SIZE; i++) pht_q[i] <= CNT_INIT;
            btb_v_q    <= '0;
            spec_ghr_q <= '0;
            ret_ghr_q  <= '0;
        end else begin
            pht_q      <= pht_d;
            btb_v_q    <= btb_v_d;
            spec_ghr_q <= spec_ghr_d;
            ret_ghr_q  <= ret_ghr_d;
        end
    end

    // BTB payload is qualified by the valid bits, so it carries no reset.
    always_ff @(posedge clock) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end
endmodule

// File: tb/tb_ysyx_bpu_gshare.sv
// Directed and random stimulus for ysyx_bpu_gshare, checked against a table-level predictor model.
// The RAS expectations follow YSYX_BPU_RAS_EN, so the same bench can be used for both builds.
module tb_ysyx_bpu_gshare;
    localparam int K_OTH = 0, K_BR = 1, K_JAL = 2, K_JALR = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_bpu_gshare_if #(.XLEN(32)) bus ();
    ysyx_bpu_gshare dut (.clock(clock), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    // stimulus for the next cycle
    logic [31:0] s_pc, s_upc, s_unpc, s_xnpc;
    int          s_kind, s_imm, s_rd, s_rs1;
    bit          s_fire, s_uv, s_ubr, s_ujalr, s_flush, s_fence, s_rst, s_xen;
    string       s_xtag;

    // reference model state
    int          m_pht [64];
    bit          m_bv  [16];
    int          m_btag[16];
    logic [31:0] m_btgt[16];
    int          m_sg, m_rg;
    logic [31:0] m_ras[$];

    function automatic bit lnk(int r);
        return (r == 1) || (r == 5);
    endfunction

    function automatic logic [31:0] enc(int kind, int imm, int rd, int rs1);
        logic [31:0] u;
        u = imm;
        case (kind)
            K_BR:    return {u[12], u[10:5], 5'd3, 5'd4, 3'b001, u[4:1], u[11], 7'b1100011};
            K_JAL:   return {u[20], u[10:1], u[11], u[19:12], 5'(rd), 7'b1101111};
            K_JALR:  return {12'h000, 5'(rs1), 3'b000, 5'(rd), 7'b1100111};
            default: return {u[24:0], 7'b0010011};
        endcase
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 64; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
        m_sg = 0;
        m_rg = 0;
        m_ras.delete();
    endfunction

    function automatic void m_predict(input logic [31:0] pc, input int kind, input int imm,
                                      input int rd, input int rs1,
                                      output logic [31:0] npc, output bit tk, output bit brp);
        int  pidx, b;
        bit  hit;
        pidx = int'((pc >> 2) % 64) ^ m_sg;
        brp  = (m_pht[pidx] >= 2);
        npc  = pc + 32'd4;
        hit  = 1'b0;
        case (kind)
            K_BR:  if (brp) npc = pc + 32'(imm);
            K_JAL: npc = pc + 32'(imm);
            K_JALR: begin
`ifdef YSYX_BPU_RAS_EN
                if (lnk(rs1) && !lnk(rd) && m_ras.size() > 0) begin
                    npc = m_ras[m_ras.size()-1];
                    hit = 1'b1;
                end
`endif
                b = int'((pc >> 2) % 16);
                if (!hit && m_bv[b] && m_btag[b] == int'((pc >> 6) % 256)) npc = m_btgt[b];
            end
            default: ;
        endcase
        tk = (npc != pc + 32'd4);
    endfunction

    function automatic void m_update();
        logic [31:0] npc;
        bit          tk, brp, utk;
        int          idx, nrg, b;
        if (s_rst || s_fence) begin
            m_clear();
            return;
        end
        m_predict(s_pc, s_kind, s_imm, s_rd, s_rs1, npc, tk, brp);
        nrg = m_rg;
        if (s_uv && s_ubr) begin
            utk = (s_unpc != s_upc + 32'd4);
            idx = int'((s_upc >> 2) % 64) ^ m_rg;
            if (utk && m_pht[idx] < 3) m_pht[idx] = m_pht[idx] + 1;
            if (!utk && m_pht[idx] > 0) m_pht[idx] = m_pht[idx] - 1;
            nrg = (m_rg * 2 + int'(utk)) % 64;
        end
        if (s_uv && s_ujalr) begin
            b = int'((s_upc >> 2) % 16);
            m_bv[b]   = 1'b1;
            m_btag[b] = int'((s_upc >> 6) % 256);
            m_btgt[b] = s_unpc;
        end
        if (s_flush) begin
            m_sg = nrg;
        end else if (s_fire) begin
            if (s_kind == K_BR) m_sg = (m_sg * 2 + int'(brp)) % 64;
`ifdef YSYX_BPU_RAS_EN
            begin
                bit push, pop;
                push = (s_kind == K_JAL || s_kind == K_JALR) && lnk(s_rd);
                pop  = (s_kind == K_JALR) && lnk(s_rs1) && m_ras.size() > 0;
                if (push && pop) m_ras[m_ras.size()-1] = s_pc + 32'd4;
                else if (push) begin
                    m_ras.push_back(s_pc + 32'd4);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                end else if (pop) void'(m_ras.pop_back());
            end
`endif
        end
        m_rg = nrg;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic lk(input logic [31:0] pc, input int kind, input int imm, input int rd,
                      input int rs1, input bit fire);
        s_pc = pc; s_kind = kind; s_imm = imm; s_rd = rd; s_rs1 = rs1; s_fire = fire;
    endtask

    task automatic ub(input logic [31:0] pc, input logic [31:0] npc);
        s_uv = 1'b1; s_ubr = 1'b1; s_upc = pc; s_unpc = npc;
    endtask

    task automatic uj(input logic [31:0] pc, input logic [31:0] npc);
        s_uv = 1'b1; s_ujalr = 1'b1; s_upc = pc; s_unpc = npc;
    endtask

    task automatic xp(input string tag, input logic [31:0] npc);
        s_xen = 1'b1; s_xtag = tag; s_xnpc = npc;
    endtask

    task automatic tick();
        logic [31:0] en;
        bit          et, bp;
        @(negedge clock);
        reset           = s_rst;
        bus.lk_pc       = s_pc;
        bus.lk_inst     = enc(s_kind, s_imm, s_rd, s_rs1);
        bus.lk_fire     = s_fire;
        bus.upd_valid   = s_uv;
        bus.upd_is_br   = s_ubr;
        bus.upd_is_jalr = s_ujalr;
        bus.upd_pc      = s_upc;
        bus.upd_npc     = s_unpc;
        bus.flush       = s_flush;
        bus.fence_time  = s_fence;
        #1;
        if (!s_rst) begin
            m_predict(s_pc, s_kind, s_imm, s_rd, s_rs1, en, et, bp);
            chk("pnpc", bus.out_pnpc, en);
            chk("ptaken", {31'd0, bus.out_ptaken}, {31'd0, et});
            if (s_xen) chk(s_xtag, bus.out_pnpc, s_xnpc);
        end
        @(posedge clock);
        m_update();
        s_fire = 1'b0; s_uv = 1'b0; s_ubr = 1'b0; s_ujalr = 1'b0;
        s_flush = 1'b0; s_fence = 1'b0; s_xen = 1'b0;
    endtask

    function automatic logic [31:0] rpc();
        case ($urandom_range(0, 9))
            0:       return 32'hFFFF_FFFC;
            1:       return 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
            default: return 32'h8000_0000 + ($urandom_range(0, 31) << 2);
        endcase
    endfunction

    function automatic int rreg();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return 1;
            2:       return 5;
            default: return 2;
        endcase
    endfunction

    initial begin
        logic [31:0] x, y, p, r;
        s_pc = 32'h8000_0000; s_kind = K_OTH; s_imm = 0; s_rd = 0; s_rs1 = 0;
        s_upc = '0; s_unpc = '0; s_xnpc = '0; s_xtag = "";
        s_fire = 0; s_uv = 0; s_ubr = 0; s_ujalr = 0; s_flush = 0; s_fence = 0; s_xen = 0;
        m_clear();
        s_rst = 1'b1;
        tick();
        tick();
        s_rst = 1'b0;

        x = 32'h8000_0010;
        lk(x, K_BR, 16, 0, 0, 0); xp("reset_br_nt", 32'h8000_0014); tick();
        lk(32'hFFFF_FFFC, K_OTH, 5, 0, 0, 0); xp("pc4_wrap", 32'h0000_0000); tick();

        // one taken retire moves the index to weakly taken; the same-cycle lookup still sees the old value
        lk(x, K_BR, 16, 0, 0, 0); ub(x, 32'h8000_0020); xp("no_bypass_br", 32'h8000_0014); tick();
        lk(x, K_BR, 16, 0, 0, 0); xp("trained_br", 32'h8000_0020); tick();

        lk(32'h8000_0100, K_JALR, 0, 0, 2, 0); uj(32'h8000_0100, 32'h8000_0400);
        xp("no_bypass_btb", 32'h8000_0104); tick();
        lk(32'h8000_0100, K_JALR, 0, 0, 2, 0); xp("btb_hit", 32'h8000_0400); tick();
        lk(32'h8000_0140, K_JALR, 0, 0, 2, 0); xp("btb_alias", 32'h8000_0144); tick();

        // saturation at both ends, with the retired history pinned to all-ones and then zero
        s_fence = 1'b1; tick();
        p = 32'h8000_0200;
        lk(p, K_OTH, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin ub(p, p + 32'h40); tick(); end
        s_flush = 1'b1; tick();
        lk(p, K_BR, 64, 0, 0, 0); xp("sat_high", p + 32'h40); tick();
        for (int i = 0; i < 9; i++) begin ub(p, p + 32'd4); tick(); end
        s_flush = 1'b1; tick();
        lk(p, K_BR, 64, 0, 0, 0); xp("sat_low", p + 32'd4); tick();

        // speculative history is discarded by a flush
        s_fence = 1'b1; tick();
        y = 32'h8000_0080;
        lk(x, K_OTH, 0, 0, 0, 0); ub(x, x + 32'd16); tick();
        for (int i = 0; i < 6; i++) begin ub(y, y + 32'd4); tick(); end
        for (int i = 0; i < 3; i++) begin lk(x, K_BR, 16, 0, 0, 1); tick(); end
        lk(x, K_BR, 16, 0, 0, 1); s_flush = 1'b1; tick();
        lk(x, K_BR, 16, 0, 0, 0); xp("flush_ghr", 32'h8000_0020); tick();
        lk(32'h8000_0100, K_JALR, 0, 0, 2, 0); uj(32'h8000_0100, 32'h8000_0400); tick();
        lk(32'h8000_0100, K_JALR, 0, 0, 2, 0); xp("btb_pre_fence", 32'h8000_0400); tick();
        s_fence = 1'b1; tick();
        lk(x, K_BR, 16, 0, 0, 0); xp("fence_pht", 32'h8000_0014); tick();
        lk(32'h8000_0100, K_JALR, 0, 0, 2, 0); xp("fence_btb", 32'h8000_0104); tick();

        // five calls then five returns
        r = 32'h8000_2000;
        lk(r, K_OTH, 0, 0, 0, 0); uj(r, 32'h8000_3000); tick();
        for (int k = 0; k < 5; k++) begin
            lk(32'h8000_1000 + 32'(k * 256), K_JAL, 64, 1, 0, 1); tick();
        end
        for (int k = 0; k < 5; k++) begin
            lk(r, K_JALR, 0, 0, 1, 1);
`ifdef YSYX_BPU_RAS_EN
            if (k < 4) xp("ras_ret", 32'h8000_1000 + 32'((4 - k) * 256) + 32'd4);
            else       xp("ras_empty_btb", 32'h8000_3000);
`else
            xp("ret_btb", 32'h8000_3000);
`endif
            tick();
        end

        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 3))
                0: lk(rpc(), K_BR, (int'($urandom_range(0, 4095)) - 2048) * 2, 0, 0, 1'b0);
                1: lk(rpc(), K_JAL, (int'($urandom_range(0, 1048575)) - 524288) * 2, rreg(), 0, 1'b0);
                2: lk(rpc(), K_JALR, 0, rreg(), rreg(), 1'b0);
                default: lk(rpc(), K_OTH, int'($urandom()), 0, 0, 1'b0);
            endcase
            s_fire = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    p = rpc();
                    ub(p, ($urandom_range(0, 1) == 0) ? p + 32'd4 : rpc());
                end
                3, 4: begin
                    p = rpc();
                    uj(p, rpc());
                end
                default: ;
            endcase
            s_flush = ($urandom_range(0, 19) == 0);
            s_fence = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
